uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 The block SHALL have parameter Prescale_width, default 6, giving the width of the oversampling prescale and edge counter.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving the number of payload bits per frame.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 RX_IN  input  1  serial line, already synchronised to clk; idle high.
REQ-006 Prescale  input  Prescale_width  oversampling ratio; legal values 8, 16, 32.
REQ-007 PAR_EN  input  1  1 = frame carries a parity bit.
REQ-008 PAR_TYP  input  1  0 = even, 1 = odd parity.
REQ-009 sampled_bit  input  1  bit from the sampling stage; valid only in the cycle where edge_cnt == Prescale>>1.
REQ-010 edge_cnt  output  Prescale_width  oversampling edge count within the current bit.
REQ-011 dat_samp_en  output  1  enables the sampling stage.
REQ-012 P_DATA  output  DATA_WIDTH  last good received word.
REQ-013 data_valid  output  1  one-cycle pulse: P_DATA updated with a good frame.
REQ-014 par_err  output  1  one-cycle pulse: parity mismatch in the frame just ended.
REQ-015 stp_err  output  1  one-cycle pulse: stop bit sampled as 0.

Function
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-017 In IDLE, edge_cnt SHALL hold 0 and dat_samp_en SHALL be 0; in every other state dat_samp_en SHALL be 1.
REQ-018 In IDLE, RX_IN == 0 SHALL move the FSM to START and latch Prescale, PAR_EN and PAR_TYP for the whole frame.
REQ-019 Outside IDLE, edge_cnt SHALL count 0..Prescale-1 and wrap to 0; each wrap SHALL advance the bit counter.
REQ-020 The capture cycle SHALL be the cycle with edge_cnt == Prescale>>1; sampled_bit SHALL be read only in that cycle.
REQ-021 START: capture of 1 is a false start, giving IDLE next cycle with counters cleared; capture of 0 gives DATA at the edge_cnt wrap.
REQ-022 DATA: the captured bit SHALL be shifted in LSB first; after DATA_WIDTH bits, the wrap gives PARITY if PAR_EN, else STOP.
REQ-023 PARITY: the expected bit SHALL be XOR-reduce(data) XOR PAR_TYP; mismatch SHALL set an internal parity flag; the wrap gives STOP.
REQ-024 STOP: the capture cycle SHALL end the frame and give IDLE next cycle, without waiting for the wrap (back-to-back frames, drift margin).
REQ-025 At frame end, one cycle after the STOP capture:
- stp_err = ~stop bit.
- par_err = parity flag AND latched PAR_EN.
- data_valid = 1 only if neither error.
- P_DATA SHALL update only when data_valid is 1, and otherwise hold.
REQ-026 Outputs data_valid, par_err and stp_err SHALL each be high for exactly one cycle per frame and SHALL otherwise be 0.
REQ-027 RX_IN low in the cycle the FSM enters IDLE SHALL start a new frame on the next cycle.
REQ-028 Changes to Prescale, PAR_EN or PAR_TYP mid-frame SHALL have no effect until the next START.

Reset
REQ-029 reset_n low SHALL asynchronously force the following, aborting any frame in progress with no pulse emitted:
- IDLE.
- edge_cnt = 0, bit counter = 0, shift register = 0, P_DATA = 0.
- data_valid = par_err = stp_err = dat_samp_en = 0.

Structure
REQ-030 State encoding, legal Prescale constants (8/16/32) and the default DATA_WIDTH SHALL live in shared package uart_rx_pkg.
REQ-031 The edge/bit counters SHALL be a sub-module edge_bit_counter with enable input and outputs edge_cnt and bit_cnt; the FSM, shift register and checks stay in uart_rx_ctrl.

Verification
REQ-032 Prescale=8, PAR_EN=0, frame 0xA5 with stop=1 -> single data_valid pulse, P_DATA=0xA5, par_err=stp_err=0, pulse 9 bit times + 5 cycles after the start edge.
REQ-033 Prescale=16, PAR_EN=1, PAR_TYP=0, 0x3C with parity 1 (wrong) -> par_err pulse, data_valid=0, P_DATA keeps previous value.
REQ-034 Prescale=32, PAR_EN=1, PAR_TYP=1, 0x01 with parity 0 and stop=0 -> stp_err pulse, par_err=0, data_valid=0.
REQ-035 Glitch: RX_IN low for 2 cycles at Prescale=8 -> START capture reads 1, FSM returns to IDLE, no output pulse.
REQ-036 Back-to-back frames 0x55 then 0xAA with no idle gap -> two data_valid pulses, P_DATA=0x55 then 0xAA.
REQ-037 reset_n low during DATA bit 4 -> immediate IDLE, all outputs 0; the next full frame 0x0F is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller: FSM encoding,
// legal oversampling ratios and the default payload width.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int PRESCALE_8         = 8;
    localparam int PRESCALE_16        = 16;
    localparam int PRESCALE_32        = 32;
    localparam int DEFAULT_DATA_WIDTH = 8;

    // Bit index runs start(0), data(1..DW), parity(DW+1), stop(DW+2).
    function automatic int bit_cnt_width(input int data_width);
        return $clog2(data_width + 3);
    endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// Oversampling edge counter and frame bit counter; both clear while disabled.
module edge_bit_counter #(
    parameter int Prescale_width = 6,
    parameter int BIT_CNT_W      = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [Prescale_width-1:0] prescale,
    output logic [Prescale_width-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]      bit_cnt,
    output logic                      edge_wrap
);

    localparam logic [Prescale_width-1:0] EDGE_ONE = 1;
    localparam logic [BIT_CNT_W-1:0]      BIT_ONE  = 1;

    // Wrap is decoded without the enable so the FSM can use it to pick
    // the enable without forming a combinational loop.
    assign edge_wrap = (edge_cnt == prescale - EDGE_ONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!enable) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (edge_wrap) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + BIT_ONE;
        end else begin
            edge_cnt <= edge_cnt + EDGE_ONE;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, LSB-first shift register, parity and
// stop checks, with one-cycle result pulses at frame end.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int Prescale_width = 6,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      RX_IN,
    input  logic [Prescale_width-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      sampled_bit,
    output logic [Prescale_width-1:0] edge_cnt,
    output logic                      dat_samp_en,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stp_err
);

    localparam int BIT_CNT_W = bit_cnt_width(DATA_WIDTH);

    rx_state_t                 state, next_state;
    logic [Prescale_width-1:0] prescale_q;
    logic                      par_en_q, par_typ_q, par_flag;
    logic [DATA_WIDTH-1:0]     shift_q;
    logic [BIT_CNT_W-1:0]      bit_cnt;
    logic                      edge_wrap, cnt_en, capture, last_data, frame_ok;

    edge_bit_counter #(
        .Prescale_width(Prescale_width),
        .BIT_CNT_W     (BIT_CNT_W)
    ) u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (cnt_en),
        .prescale (prescale_q),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .edge_wrap(edge_wrap)
    );

    assign capture     = (edge_cnt == (prescale_q >> 1));
    assign last_data   = (bit_cnt == BIT_CNT_W'(DATA_WIDTH));
    assign dat_samp_en = (state != IDLE);
    assign frame_ok    = sampled_bit && !(par_flag && par_en_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!RX_IN) next_state = START;
            START: begin
                if (capture && sampled_bit) next_state = IDLE;
                else if (edge_wrap)         next_state = DATA;
            end
            DATA:    if (edge_wrap && last_data) next_state = par_en_q ? PARITY : STOP;
            PARITY:  if (edge_wrap) next_state = STOP;
            STOP:    if (capture) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        // Counters start at 0 in the first START cycle and clear on any return to IDLE.
        cnt_en = (state != IDLE) && (next_state != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_flag   <= 1'b0;
            shift_q    <= '0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            if (state == IDLE && !RX_IN) begin
                prescale_q <= Prescale;
                par_en_q   <= PAR_EN;
                par_typ_q  <= PAR_TYP;
                par_flag   <= 1'b0;
            end
            if (state == DATA && capture)
                shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
            if (state == PARITY && capture)
                par_flag <= sampled_bit ^ (^shift_q) ^ par_typ_q;
            // Frame ends at the stop capture, leaving half a bit of drift margin.
            if (state == STOP && capture) begin
                stp_err    <= ~sampled_bit;
                par_err    <= par_flag && par_en_q;
                data_valid <= frame_ok;
                if (frame_ok) P_DATA <= shift_q;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: serial frames are driven on RX_IN
// and each result pulse is compared with a frame-level reference model.
module tb_uart_rx_ctrl;
    import uart_rx_pkg::*;

    localparam int PW = 6;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          RX_IN = 1'b1;
    logic [PW-1:0] Prescale = PW'(8);
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic          sampled_bit;
    logic [PW-1:0] edge_cnt;
    logic          dat_samp_en;
    logic [DW-1:0] P_DATA;
    logic          data_valid, par_err, stp_err;

    // Ideal sampling stage: the line value is the bit value mid-bit.
    assign sampled_bit = RX_IN;

    uart_rx_ctrl #(.Prescale_width(PW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n), .RX_IN(RX_IN), .Prescale(Prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .sampled_bit(sampled_bit),
        .edge_cnt(edge_cnt), .dat_samp_en(dat_samp_en), .P_DATA(P_DATA),
        .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic          dv, pe, se;
        logic [DW-1:0] pd;
    } ev_t;

    ev_t           exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] last_good = '0;

    // Every result pulse must match the next expected frame outcome.
    initial forever begin
        @(negedge clk);
        if (reset_n && (data_valid || par_err || stp_err)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: dv=%b pe=%b se=%b at cycle %0d, expected no pulse",
                         data_valid, par_err, stp_err, cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if ({data_valid, par_err, stp_err, P_DATA} !== {e.dv, e.pe, e.se, e.pd} || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL frame_result: got dv=%b pe=%b se=%b P_DATA=%h cycle %0d, expected dv=%b pe=%b se=%b P_DATA=%h cycle %0d",
                             data_valid, par_err, stp_err, P_DATA, cyc, e.dv, e.pe, e.se, e.pd, e.cyc);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic int pick_p();
        case ($urandom % 3)
            0:       return PRESCALE_8;
            1:       return PRESCALE_16;
            default: return PRESCALE_32;
        endcase
    endfunction

    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic send_frame(input int p, input bit pen, input bit ptyp, input logic [DW-1:0] d,
                              input bit bad_par, input bit stop, input int gap);
        ev_t  e;
        int   e0;
        logic pbit;
        Prescale = PW'(p); PAR_EN = pen; PAR_TYP = ptyp; RX_IN = 1'b0;
        e0     = cyc + 1;
        pbit   = (^d) ^ ptyp ^ bad_par;
        e.pe   = pen && bad_par;
        e.se   = !stop;
        e.dv   = !e.pe && !e.se;
        e.cyc  = e0 + (1 + DW + (pen ? 1 : 0)) * p + p / 2 + 1;
        if (e.dv) last_good = d;
        e.pd   = last_good;
        exp_q.push_back(e);
        @(posedge clk); #1;
        // Config changes after the start edge must be ignored by this frame.
        Prescale = PW'(pick_p()); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
        repeat (p - 1) @(posedge clk);
        #1;
        Prescale = PW'(p); PAR_EN = pen; PAR_TYP = ptyp;
        for (int i = 0; i < DW; i++) begin
            RX_IN = d[i];
            repeat (p) @(posedge clk);
            #1;
        end
        if (pen) begin
            RX_IN = pbit;
            repeat (p) @(posedge clk);
            #1;
        end
        RX_IN = stop;
        repeat (p) @(posedge clk);
        #1;
        RX_IN = 1'b1;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({data_valid, par_err, stp_err, dat_samp_en, P_DATA, edge_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: dv=%b pe=%b se=%b en=%b P_DATA=%h edge_cnt=%0d, expected all 0",
                     data_valid, par_err, stp_err, dat_samp_en, P_DATA, edge_cnt);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (dat_samp_en !== 1'b0 || edge_cnt !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: en=%b edge_cnt=%0d, expected en=0 edge_cnt=0", dat_samp_en, edge_cnt);
        end
    endtask

    task automatic test_basic();
        send_frame(8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 2);
        checks++;
        if (P_DATA !== 8'hA5 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_frame: P_DATA=%h pending=%0d, expected P_DATA=a5 pending=0", P_DATA, exp_q.size());
        end
    endtask

    task automatic test_parity_error();
        send_frame(16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 2);
        checks++;
        if (P_DATA !== 8'hA5 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL parity_error_hold: P_DATA=%h pending=%0d, expected P_DATA=a5 pending=0", P_DATA, exp_q.size());
        end
    endtask

    task automatic test_stop_error();
        send_frame(32, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 32);
        checks++;
        if (P_DATA !== 8'hA5 || exp_q.size() != 0 || dat_samp_en !== 1'b0) begin
            errors++;
            $display("FAIL stop_error_hold: P_DATA=%h pending=%0d en=%b, expected P_DATA=a5 pending=0 en=0",
                     P_DATA, exp_q.size(), dat_samp_en);
        end
    endtask

    task automatic test_glitch();
        Prescale = PW'(8); PAR_EN = 1'b0; RX_IN = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        RX_IN = 1'b1;
        checks++;
        if (dat_samp_en !== 1'b1 || edge_cnt !== PW'(1)) begin
            errors++;
            $display("FAIL glitch_start: en=%b edge_cnt=%0d, expected en=1 edge_cnt=1", dat_samp_en, edge_cnt);
        end
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if (dat_samp_en !== 1'b0 || edge_cnt !== '0) begin
            errors++;
            $display("FAIL glitch_abort: en=%b edge_cnt=%0d, expected en=0 edge_cnt=0", dat_samp_en, edge_cnt);
        end
        repeat (20) begin @(posedge clk); #1; end
    endtask

    task automatic test_back_to_back();
        send_frame(16, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 0);
        send_frame(16, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b1, 2);
        checks++;
        if (P_DATA !== 8'hAA || exp_q.size() != 0) begin
            errors++;
            $display("FAIL back_to_back: P_DATA=%h pending=%0d, expected P_DATA=aa pending=0", P_DATA, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [DW-1:0] d;
        d = 8'h3A;
        Prescale = PW'(8); PAR_EN = 1'b0; RX_IN = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        for (int i = 0; i < 4; i++) begin
            RX_IN = d[i];
            repeat (8) begin @(posedge clk); #1; end
        end
        RX_IN = d[4];
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (dat_samp_en !== 1'b1) begin
            errors++;
            $display("FAIL frame_in_progress: en=%b, expected 1", dat_samp_en);
        end
        #2 reset_n = 1'b0;
        #1;
        last_good = '0;
        checks++;
        if ({data_valid, par_err, stp_err, dat_samp_en, P_DATA, edge_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset: dv=%b pe=%b se=%b en=%b P_DATA=%h edge_cnt=%0d, expected all 0",
                     data_valid, par_err, stp_err, dat_samp_en, P_DATA, edge_cnt);
        end
        RX_IN = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        send_frame(8, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1, 2);
        checks++;
        if (P_DATA !== 8'h0F || exp_q.size() != 0) begin
            errors++;
            $display("FAIL after_reset_frame: P_DATA=%h pending=%0d, expected P_DATA=0f pending=0", P_DATA, exp_q.size());
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            int            p;
            bit            pen, ptyp, bad, stop;
            logic [DW-1:0] d;
            p    = pick_p();
            pen  = 1'($urandom);
            ptyp = 1'($urandom);
            d    = DW'($urandom);
            bad  = pen && ($urandom % 4 == 0);
            stop = ($urandom % 5 != 0);
            // A low stop bit re-triggers START mid-bit; leave idle time so that false start settles.
            send_frame(p, pen, ptyp, d, bad, stop, stop ? int'($urandom % 3) : p);
        end
        repeat (4) begin @(posedge clk); #1; end
        checks++;
        if (exp_q.size() != 0 || P_DATA !== last_good) begin
            errors++;
            $display("FAIL random_frames: pending=%0d P_DATA=%h, expected pending=0 P_DATA=%h",
                     exp_q.size(), P_DATA, last_good);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity_error();
        test_stop_error();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
